// File: rtl/four_way_rr_arbiter.sv
// Round-robin arbiter, 4 requesters, registered one-hot grant held until release.
// Ports: clk, rst (async high), req[3:0], done -> gnt[3:0], gnt_valid, timeout.
// Optional hold-limit revocation is built when RR_ARB_TIMEOUT_EN is defined.
module four_way_rr_arbiter #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx;
  logic [1:0] owner, owner_nx;
  logic [1:0] pick;
  logic       found;
  logic [3:0] gnt_nx;
  logic       gnt_valid_nx;
  logic       rel;
  logic       expire;

  // First set request scanning upward from ptr, wrapping mod 4.
  always_comb begin : arb
    logic [1:0] idx;
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign rel = done | ~req[owner];

`ifdef RR_ARB_TIMEOUT_EN
  logic [7:0] cnt, cnt_nx;
  logic       timeout_nx;

  // A normal release on the same edge wins; no pulse then.
  assign expire = (cnt == 8'(TIMEOUT)) & ~rel;
`else
  assign expire  = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      owner     <= 2'd0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      cnt       <= 8'd0;
      timeout   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      owner     <= owner_nx;
      gnt       <= gnt_nx;
      gnt_valid <= gnt_valid_nx;
`ifdef RR_ARB_TIMEOUT_EN
      cnt       <= cnt_nx;
      timeout   <= timeout_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (found) state_nx = GRANT;
      GRANT:   if (rel || expire) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    gnt_nx       = gnt;
    gnt_valid_nx = gnt_valid;
    ptr_nx       = ptr;
    owner_nx     = owner;
`ifdef RR_ARB_TIMEOUT_EN
    cnt_nx       = cnt;
    timeout_nx   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (found) begin
          gnt_nx       = 4'b0001 << pick;
          gnt_valid_nx = 1'b1;
          owner_nx     = pick;
`ifdef RR_ARB_TIMEOUT_EN
          cnt_nx       = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (rel || expire) begin
          gnt_nx       = 4'b0000;
          gnt_valid_nx = 1'b0;
          ptr_nx       = owner + 2'd1;
`ifdef RR_ARB_TIMEOUT_EN
          timeout_nx   = expire;
`endif
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          cnt_nx       = cnt + 8'd1;
`endif
        end
      end
      default: begin
        gnt_nx       = 4'b0000;
        gnt_valid_nx = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_four_way_rr_arbiter.sv
// Directed bench for four_way_rr_arbiter: reset, rotation, owner drop,
// hold, async reset, random one-hot sweep, timeout on/off behaviour.
module tb_four_way_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  four_way_rr_arbiter #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] rot_exp [9];
  logic [3:0] prev;

  initial begin
    rot_exp[0] = 4'b0001; rot_exp[1] = 4'b0000;
    rot_exp[2] = 4'b0010; rot_exp[3] = 4'b0000;
    rot_exp[4] = 4'b0100; rot_exp[5] = 4'b0000;
    rot_exp[6] = 4'b1000; rot_exp[7] = 4'b0000;
    rot_exp[8] = 4'b0001;

    rst  = 1'b1;
    req  = 4'b0000;
    done = 1'b0;
    step();
    step();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", {3'b0, gnt_valid}, 4'd0);
    chk("rst_timeout", {3'b0, timeout}, 4'd0);
    rst = 1'b0;
    step();
    chk("idle_gnt", gnt, 4'b0000);

    req = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      done = k[0];
      step();
      chk($sformatf("rot%0d", k), gnt, rot_exp[k]);
      chk($sformatf("rot%0d_valid", k), {3'b0, gnt_valid},
          {3'b0, |rot_exp[k]});
    end
    done = 1'b1;
    req  = 4'b0000;
    step();
    chk("rot_release", gnt, 4'b0000);
    done = 1'b0;

    // ptr now 1
    req = 4'b0010;
    step();
    chk("drop_grant", gnt, 4'b0010);
    req = 4'b0001;
    step();
    chk("drop_release", gnt, 4'b0000);
    chk("drop_valid", {3'b0, gnt_valid}, 4'd0);
    req = 4'b0011;
    step();
    chk("drop_next", gnt, 4'b0001);
    for (int k = 0; k < 3; k++) begin
      req = (k == 1) ? 4'b1111 : 4'b0011;
      step();
      chk($sformatf("hold%0d", k), gnt, 4'b0001);
    end
    done = 1'b1;
    step();
    chk("hold_release", gnt, 4'b0000);
    done = 1'b0;

    // ptr now 1
    req = 4'b0100;
    step();
    chk("pre_rst_grant", gnt, 4'b0100);
    rst = 1'b1;
    #2;
    chk("async_rst_gnt", gnt, 4'b0000);
    chk("async_rst_valid", {3'b0, gnt_valid}, 4'd0);
    step();
    rst = 1'b0;
    req = 4'b0011;
    step();
    chk("post_rst_ptr0", gnt, 4'b0001);
    done = 1'b1;
    req  = 4'b0000;
    step();
    chk("post_rst_release", gnt, 4'b0000);
    done = 1'b0;

    prev = 4'b0000;
    for (int k = 0; k < 1000; k++) begin
      req  = 4'($urandom_range(0, 15));
      done = ($urandom_range(0, 3) == 0);
      step();
      chk("rand_onehot", {3'b0, ($countones(gnt) > 1)}, 4'd0);
      chk("rand_valid", {3'b0, gnt_valid}, {3'b0, |gnt});
      if (prev != 4'b0000 && gnt != 4'b0000)
        chk("rand_gap", gnt, prev);
`ifndef RR_ARB_TIMEOUT_EN
      chk("rand_timeout", {3'b0, timeout}, 4'd0);
`endif
      prev = gnt;
    end
    req  = 4'b0000;
    done = 1'b1;
    step();
    step();
    chk("rand_end", gnt, 4'b0000);
    done = 1'b0;

    req = 4'b1000;
    step();
    chk("to_grant", gnt, 4'b1000);
`ifdef RR_ARB_TIMEOUT_EN
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("to_hold%0d", k), gnt, 4'b1000);
      chk($sformatf("to_hold%0d_pulse", k), {3'b0, timeout}, 4'd0);
    end
    step();
    chk("to_revoke", gnt, 4'b0000);
    chk("to_pulse", {3'b0, timeout}, 4'd1);
    step();
    chk("to_regrant", gnt, 4'b1000);
    chk("to_pulse_end", {3'b0, timeout}, 4'd0);
`else
    for (int k = 0; k < 100; k++) begin
      step();
      chk("nto_hold", gnt, 4'b1000);
      chk("nto_timeout", {3'b0, timeout}, 4'd0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/four_way_rr_arbiter.md
# four_way_rr_arbiter

Round-robin arbiter for four request lines; produces the registered one-hot grant that drives the a/b/c/d inputs of the 4-to-2 encoder stage directly downstream. Guarantees the encoder only ever sees all-zero or exactly-one-hot input. Grants are held until released, and fairness rotates among requesters. Single clock domain.

## Interface
Parameters:
- TIMEOUT, 15: grant-hold limit in cycles, 1..255; used only when the timeout feature is compiled in.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request lines; bit 0 = a, bit 1 = b, bit 2 = c, bit 3 = d.
- done  input  1  owner releases its grant; sampled only in GRANT.
- gnt  output  4  registered one-hot grant to encoder inputs a..d (bit 0 = a); all zero when idle.
- gnt_valid  output  1  high while any gnt bit is high (equals OR of gnt, registered).
- timeout  output  1  one-cycle pulse when a grant is revoked by timeout; constant 0 when the feature is not compiled in.

## Operation
- State: FSM {IDLE, GRANT}, 2-bit priority pointer ptr, 2-bit owner index, 8-bit hold counter (only with the feature).
- Reset, asynchronous: state = IDLE, gnt = 0000, gnt_valid = 0, timeout = 0, ptr = 0, counter = 0.
- IDLE:
  - If req != 0, pick the first set bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Set gnt to that one-hot, gnt_valid = 1, owner = index, and go to GRANT.
  - If req == 0, stay in IDLE.
  - done is ignored in IDLE.
- GRANT:
  - Hold gnt unchanged while req[owner] = 1 and done = 0.
  - Release when done = 1 OR req[owner] = 0. On release: gnt = 0000, gnt_valid = 0, ptr = owner+1 (mod 4, 3 wraps to 0), state = IDLE.
  - Requests from other lines during GRANT are not latched. They are re-evaluated in IDLE.
- Mandatory gap: after any release, at least one cycle with gnt = 0000 before the next grant. The encoder never sees a direct one-hot-to-one-hot change.
- gnt never has more than one bit set, under any input including req = 1111.

## Timing
- Grant latency: req sampled at edge N in IDLE, so gnt is valid after edge N (1 cycle).
- Release latency: done or req[owner] drop sampled at edge M, so gnt = 0 after edge M.
- Next grant is sampled no earlier than edge M+1, so it appears after edge M+1.
- Back-to-back throughput: grant periods are separated by exactly 1 idle cycle when requests stay pending.
- Simultaneous done and timeout expiry on the same edge: treat as a normal release, so timeout stays 0.
- Reset asserted mid-grant: gnt drops to 0 immediately (asynchronous), and ptr returns to 0.
- No combinational path from req or done to gnt.

## Configuration
- Macro: RR_ARB_TIMEOUT_EN.
- Defined:
  - The counter clears on entry to GRANT and increments each cycle in GRANT.
  - When the counter reaches TIMEOUT with no normal release on that edge, revoke exactly as a release (ptr = owner+1) and pulse timeout high for 1 cycle.
  - Resulting grant length is at most TIMEOUT+1 cycles.
- Not defined:
  - No counter is built, timeout is tied to 0, and grants are held indefinitely.
  - The port list is identical in both builds.

## Test plan
- Reset: assert rst mid-grant with gnt = 0100 → gnt = 0000, gnt_valid = 0 without waiting for a clock edge; after release, req = 0001 grants 0001 (ptr = 0).
- Rotation: req held at 1111 with done pulsed 1 cycle after each grant → gnt sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- Owner drop: grant 0010, then deassert req[1] with done = 0 → gnt = 0000 the next cycle; with req = 0011 pending, the next grant is 0001 (ptr wrapped past 1 to 2, 3, 0).
- One-hot check: drive random req and done for 1000 cycles → gnt always in {0000, 0001, 0010, 0100, 1000}, gnt_valid == |gnt, and at least one zero cycle between any two different non-zero gnt values.
- Timeout (RR_ARB_TIMEOUT_EN, TIMEOUT = 4): req = 1000 held with done = 0 → gnt = 1000 for 5 cycles, then 0000 with a 1-cycle timeout pulse, then 1000 re-granted after 1 idle cycle.
- Timeout compiled out: same stimulus → gnt = 1000 held for 100 cycles, timeout constantly 0.
